// File: rtl/key_pulse_gen.sv
// Push-button front-end: synchronises, debounces and auto-repeats two raw keys into
// mutually exclusive single-cycle add/sub pulses.
module key_pulse_gen #(
    parameter int DEBOUNCE_CYCLES      = 2_000_000,
    parameter int REPEAT_DELAY_CYCLES  = 50_000_000,
    parameter int REPEAT_PERIOD_CYCLES = 10_000_000,
    parameter int KEY_ACTIVE_LOW       = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_add_raw,
    input  logic       key_sub_raw,
    output logic       key_add,
    output logic       key_sub,
    output logic [1:0] key_level
);

    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES);
    localparam int REP_MAX = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                             REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [REP_W-1:0] DELAY_LOAD  = REP_W'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [REP_W-1:0] PERIOD_LOAD = REP_W'(REPEAT_PERIOD_CYCLES - 1);
    localparam logic             RELEASED_RAW = (KEY_ACTIVE_LOW != 0);

    typedef enum logic [1:0] {S_IDLE, S_DELAY, S_REPEAT, S_LOCK} state_t;

    // Index 1 = add key, index 0 = sub key, matching key_level.
    logic [1:0]       w_raw;
    logic [1:0]       w_pressed;
    logic [1:0]       r_sync_p0;
    logic [1:0]       r_sync_p1;
    logic [1:0]       r_level;
    logic [DB_W-1:0]  r_db_cnt  [2];
    state_t           r_state   [2];
    logic [REP_W-1:0] r_rep_cnt [2];
    logic [1:0]       r_pulse;

    assign w_raw     = {key_add_raw, key_sub_raw};
    assign w_pressed = (KEY_ACTIVE_LOW != 0) ? ~r_sync_p1 : r_sync_p1;

    // Stage p0/p1: two-flop synchroniser, reset to the released raw level
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync_p0 <= {2{RELEASED_RAW}};
            r_sync_p1 <= {2{RELEASED_RAW}};
        end else begin
            r_sync_p0 <= w_raw;
            r_sync_p1 <= r_sync_p0;
        end
    end

    // Debounce: the new level must persist for DEBOUNCE_CYCLES consecutive samples
    always_ff @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                r_db_cnt[k] <= '0;
                r_level[k]  <= 1'b0;
            end else if (w_pressed[k] != r_level[k]) begin
                if (r_db_cnt[k] == DB_LAST) begin
                    r_level[k]  <= w_pressed[k];
                    r_db_cnt[k] <= '0;
                end else begin
                    r_db_cnt[k] <= r_db_cnt[k] + 1'b1;
                end
            end else begin
                r_db_cnt[k] <= '0;
            end
        end
    end

    // Repeat FSM: the other key's level forces LOCK, which keeps the two pulses exclusive
    always_ff @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                r_state[k]   <= S_IDLE;
                r_rep_cnt[k] <= '0;
                r_pulse[k]   <= 1'b0;
            end else begin
                r_pulse[k] <= 1'b0;
                if (!r_level[k]) begin
                    r_state[k]   <= S_IDLE;
                    r_rep_cnt[k] <= '0;
                end else begin
                    case (r_state[k])
                        S_IDLE: begin
                            if (r_level[1-k]) begin
                                r_state[k] <= S_LOCK;
                            end else begin
                                r_state[k]   <= S_DELAY;
                                r_rep_cnt[k] <= DELAY_LOAD;
                                r_pulse[k]   <= 1'b1;
                            end
                        end
                        S_DELAY, S_REPEAT: begin
                            if (r_level[1-k]) begin
                                r_state[k]   <= S_LOCK;
                                r_rep_cnt[k] <= '0;
                            end else if (r_rep_cnt[k] == '0) begin
                                r_state[k]   <= S_REPEAT;
                                r_rep_cnt[k] <= PERIOD_LOAD;
                                r_pulse[k]   <= 1'b1;
                            end else begin
                                r_rep_cnt[k] <= r_rep_cnt[k] - 1'b1;
                            end
                        end
                        S_LOCK: begin
                            r_state[k] <= S_LOCK;
                        end
                        default: begin
                            r_state[k] <= S_IDLE;
                        end
                    endcase
                end
            end
        end
    end

    assign key_add   = r_pulse[1];
    assign key_sub   = r_pulse[0];
    assign key_level = r_level;

endmodule

// File: tb/tb_key_pulse_gen.sv
// Directed bench for key_pulse_gen: pulse timing, bounce rejection, repeat, lockout, reset.
module tb_key_pulse_gen;

    localparam int DB  = 4;
    localparam int DLY = 20;
    localparam int PER = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       add_raw = 1'b1;
    logic       sub_raw = 1'b1;
    logic       key_add;
    logic       key_sub;
    logic [1:0] key_level;

    always #5 clk = ~clk;

    key_pulse_gen #(
        .DEBOUNCE_CYCLES      (DB),
        .REPEAT_DELAY_CYCLES  (DLY),
        .REPEAT_PERIOD_CYCLES (PER),
        .KEY_ACTIVE_LOW       (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_add_raw (add_raw),
        .key_sub_raw (sub_raw),
        .key_add     (key_add),
        .key_sub     (key_sub),
        .key_level   (key_level)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int both_hi = 0;
    logic [1:0] lvl_or;
    int add_t[$];
    int sub_t[$];
    int exp_add[$];

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n clock edges, sampling 1 time unit after each edge.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (key_add === 1'b1) add_t.push_back(cyc);
            if (key_sub === 1'b1) sub_t.push_back(cyc);
            if (key_add === 1'b1 && key_sub === 1'b1) both_hi++;
            lvl_or = lvl_or | key_level;
        end
    endtask

    task automatic start();
        cyc     = 0;
        both_hi = 0;
        lvl_or  = 2'b00;
        add_t.delete();
        sub_t.delete();
    endtask

    task automatic chk_pulses(input string tag);
        chk({tag, " count"}, add_t.size(), exp_add.size());
        for (int i = 0; i < exp_add.size() && i < add_t.size(); i++)
            chk($sformatf("%s #%0d", tag, i), add_t[i], exp_add[i]);
    endtask

    initial begin
        lvl_or = 2'b00;

        // Reset state
        run(3);
        chk("reset add", int'(key_add), 0);
        chk("reset sub", int'(key_sub), 0);
        chk("reset lvl", int'(key_level), 0);
        rst = 1'b0;
        run(10);
        chk("idle lvl", int'(key_level), 0);

        // Clean press/release
        start();
        add_raw = 1'b0;
        run(5);  chk("s1 lvl before rise", int'(key_level), 0);
        run(1);  chk("s1 lvl rise", int'(key_level), 2);
        run(4);
        add_raw = 1'b1;
        run(5);  chk("s1 lvl before fall", int'(key_level), 2);
        run(1);  chk("s1 lvl fall", int'(key_level), 0);
        run(14);
        exp_add = '{7};
        chk_pulses("s1 add");
        chk("s1 sub count", sub_t.size(), 0);

        // Bounce rejection
        start();
        for (int i = 0; i < 40; i++) begin
            sub_raw = ((i % 4) < 3) ? 1'b0 : 1'b1;
            run(1);
        end
        sub_raw = 1'b1;
        run(20);
        chk("s2 add count", add_t.size(), 0);
        chk("s2 sub count", sub_t.size(), 0);
        chk("s2 lvl seen", int'(lvl_or), 0);

        // Auto-repeat
        start();
        add_raw = 1'b0;
        run(70);
        add_raw = 1'b1;
        run(30);
        exp_add = '{7, 27, 35, 43, 51, 59, 67, 75};
        chk_pulses("s3 add");
        chk("s3 sub count", sub_t.size(), 0);

        // Mutual lockout
        start();
        add_raw = 1'b0;
        run(25);
        sub_raw = 1'b0;
        run(40);
        chk("s4 lvl both", int'(key_level), 3);
        sub_raw = 1'b1;
        run(30);
        chk("s4 lvl add only", int'(key_level), 2);
        add_raw = 1'b1;
        run(20);
        exp_add = '{7, 27};
        chk_pulses("s4 add");
        chk("s4 sub count", sub_t.size(), 0);
        chk("s4 both high", both_hi, 0);
        start();
        add_raw = 1'b0;
        run(10);
        add_raw = 1'b1;
        run(20);
        exp_add = '{7};
        chk_pulses("s4 repress add");

        // Simultaneous press
        start();
        add_raw = 1'b0;
        sub_raw = 1'b0;
        run(10);
        chk("s5 lvl", int'(key_level), 3);
        run(40);
        chk("s5 lvl held", int'(key_level), 3);
        add_raw = 1'b1;
        sub_raw = 1'b1;
        run(20);
        chk("s5 add count", add_t.size(), 0);
        chk("s5 sub count", sub_t.size(), 0);

        // Reset mid-hold
        start();
        add_raw = 1'b0;
        run(30);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            run(1);
            chk($sformatf("s6 outputs in reset %0d", i),
                int'({key_add, key_sub, key_level}), 0);
        end
        rst = 1'b0;
        run(27);
        add_raw = 1'b1;
        run(20);
        exp_add = '{7, 27, 40, 60};
        chk_pulses("s6 add");
        chk("s6 sub count", sub_t.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
